myhardware_timer_master: RTL
============================

// Module: myhardware_timer_master
// PURPOSE
// Avalon-MM initiator that drives the myhardware interval-timer slave (16-bit data, 3-bit word address,
// registered readdata, no waitrequest). Turns simple commands (CONFIG, STOP, SNAPSHOT) into timer
// register sequences, services the timer irq by clearing status, and counts timeouts for the fabric.
// Sits between control logic and the timer's s1 port; one master, one slave, point-to-point.
// PARAMETERS
// TICK_W    32  width of tick_count
// TICK_SAT  1   1: tick_count saturates at all-ones; 0: wraps to 0
// PORTS
// clk            in   1       system clock, all logic rising-edge
// reset          in   1       synchronous, active-high
// cmd_valid      in   1       command request
// cmd_ready      out  1       command accepted when cmd_valid && cmd_ready at rising edge
// cmd_op         in   2       0=NOP 1=CONFIG 2=STOP 3=SNAPSHOT
// cmd_period     in   32      CONFIG: timer period value (loaded as {period_h,period_l})
// cmd_continuous in   1       CONFIG: control CONT bit
// cmd_irq_en     in   1       CONFIG: control ITO bit
// snap_valid     out  1       one-cycle pulse, snap_value updated
// snap_value     out  32      last captured {snap_h,snap_l}
// tick_pulse     out  1       one-cycle pulse per serviced timeout
// tick_count     out  TICK_W  serviced timeouts since reset or last CONFIG
// avm_address    out  3       timer word address
// avm_chipselect out  1       timer select
// avm_write_n    out  1       active-low write
// avm_writedata  out  16      write data
// avm_readdata   in   16      timer readdata, valid the cycle AFTER address is driven
// timer_irq      in   1       timer interrupt (level)
// BEHAVIOUR
// - Reset: state IDLE; cmd_ready=0 during reset cycle; snap_valid=0, snap_value=0, tick_pulse=0,
//   tick_count=0; avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0. Reset mid-sequence
//   aborts immediately; no further bus cycles issued.
// - Every bus state lasts exactly 1 cycle; all avm_* outputs registered from state.
// - cmd_ready = (state==IDLE) && !timer_irq. IRQ service has priority over new commands.
// - CONFIG: WR_PL(a=2,d=period[15:0]) -> WR_PH(a=3,d=period[31:16]) -> WR_CTRL(a=1,
//   d={12'b0,stop=0,start=1,cont,ito}) -> IDLE. Clears tick_count at acceptance. 3 bus cycles; cmd_ready
//   high again 4 cycles after acceptance.
// - STOP: WR_STOP(a=1,d=16'h0008) -> IDLE. Note ITO also cleared by this write.
// - NOP: accepted, no bus activity, stays IDLE.
// - SNAPSHOT: WR_SNAP(a=4,d=0) -> RD_L(a=4,read) -> RD_H(a=5,read; capture readdata as low half)
//   -> CAP_H(bus idle; capture readdata as high half) -> IDLE; snap_value updated and snap_valid
//   pulsed in the first IDLE cycle. Read states: chipselect=1, write_n=1.
// - IRQ service: in IDLE with timer_irq=1: CLR_ST(a=0,d=0 write) -> GUARD(bus idle, timer_irq ignored)
//   -> IDLE. tick_pulse asserted and tick_count incremented in the GUARD cycle. GUARD exists because
//   irq drops one cycle after the status write; it prevents double counting.
// - timer_irq asserted mid-command: ignored until IDLE; serviced before the next command.
// - tick_count at max: TICK_SAT=1 holds all-ones (tick_pulse still fires); TICK_SAT=0 wraps to 0.
// - cmd_valid held with cmd_op unchanged after acceptance is a new command only if accepted again.
// - Outside bus states: chipselect=0, write_n=1, address/writedata hold 0.
// TESTING
// - CONFIG period=32'h0001_86A0, cont=1, ito=1 -> writes a2=86A0, a3=0001, a1=0007 on 3 consecutive cycles.
// - With timer model, period=9 continuous: after 10 timeouts tick_count=10, exactly 10 status writes (a0).
// - SNAPSHOT when counter=32'h0000_1234 -> a4 write, reads a4/a5, snap_value=0000_1234, one snap_valid.
// - irq rises during SNAPSHOT RD_L -> snapshot completes, then CLR_ST, tick_count+1, cmd_ready low meanwhile.
// - TICK_W=4, TICK_SAT=1, 20 timeouts -> tick_count=4'hF; TICK_SAT=0 -> tick_count=4'h4.
// - reset asserted in WR_PH -> next cycle chipselect=0, write_n=1, no WR_CTRL issued, tick_count=0.

Source files
------------

// File: rtl/myhardware_timer_master.sv
// Avalon-MM initiator for the myhardware interval-timer slave.
// Turns CONFIG / STOP / SNAPSHOT commands into timer register sequences,
// services the timer interrupt by clearing status, and counts serviced timeouts.
module myhardware_timer_master #(
   parameter int TICK_W   = 32,
   parameter bit TICK_SAT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [31:0]       cmd_period,
   input  logic              cmd_continuous,
   input  logic              cmd_irq_en,
   output logic              snap_valid,
   output logic [31:0]       snap_value,
   output logic              tick_pulse,
   output logic [TICK_W-1:0] tick_count,
   output logic [2:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [15:0]       avm_writedata,
   input  logic [15:0]       avm_readdata,
   input  logic              timer_irq
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WR_STOP,
      S_WR_SNAP, S_RD_L, S_RD_H, S_CAP_H, S_CLR_ST, S_GUARD
   } state_t;

   localparam logic [1:0] OP_CONFIG   = 2'd1;
   localparam logic [1:0] OP_STOP     = 2'd2;
   localparam logic [1:0] OP_SNAPSHOT = 2'd3;

   state_t      state, state_nxt;
   logic        accept;
   logic [15:0] period_hi_p0;
   logic        cont_p0, ito_p0;
   logic [15:0] snap_lo_p0;
   logic        bus_cs, bus_wr_n;
   logic [2:0]  bus_addr;
   logic [15:0] bus_wdata;

   // Timeout counter step: hold at all-ones when saturating, otherwise wrap.
   function automatic logic [TICK_W-1:0] tick_next(input logic [TICK_W-1:0] cnt);
      if (TICK_SAT && (&cnt))
         tick_next = cnt;
      else
         tick_next = cnt + {{(TICK_W-1){1'b0}}, 1'b1};
   endfunction

   // A pending interrupt blocks new commands so it is serviced first.
   assign cmd_ready = (state == S_IDLE) && !timer_irq && !reset;
   assign accept    = cmd_valid && cmd_ready;

   // Next-state sequencing: every bus state lasts exactly one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (timer_irq)
               state_nxt = S_CLR_ST;
            else if (accept) begin
               case (cmd_op)
                  OP_CONFIG:   state_nxt = S_WR_PL;
                  OP_STOP:     state_nxt = S_WR_STOP;
                  OP_SNAPSHOT: state_nxt = S_WR_SNAP;
                  default:     state_nxt = S_IDLE;
               endcase
            end
         end
         S_WR_PL:   state_nxt = S_WR_PH;
         S_WR_PH:   state_nxt = S_WR_CTRL;
         S_WR_CTRL: state_nxt = S_IDLE;
         S_WR_STOP: state_nxt = S_IDLE;
         S_WR_SNAP: state_nxt = S_RD_L;
         S_RD_L:    state_nxt = S_RD_H;
         S_RD_H:    state_nxt = S_CAP_H;
         S_CAP_H:   state_nxt = S_IDLE;
         S_CLR_ST:  state_nxt = S_GUARD;
         S_GUARD:   state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Bus values for the state being entered; registered below so avm_* line up with state.
   always_comb begin
      bus_cs    = 1'b0;
      bus_wr_n  = 1'b1;
      bus_addr  = 3'd0;
      bus_wdata = 16'h0000;
      case (state_nxt)
         S_WR_PL:   begin bus_cs = 1'b1; bus_wr_n = 1'b0; bus_addr = 3'd2; bus_wdata = cmd_period[15:0]; end
         S_WR_PH:   begin bus_cs = 1'b1; bus_wr_n = 1'b0; bus_addr = 3'd3; bus_wdata = period_hi_p0; end
         S_WR_CTRL: begin bus_cs = 1'b1; bus_wr_n = 1'b0; bus_addr = 3'd1;
                          bus_wdata = {12'h000, 1'b0, 1'b1, cont_p0, ito_p0}; end
         S_WR_STOP: begin bus_cs = 1'b1; bus_wr_n = 1'b0; bus_addr = 3'd1; bus_wdata = 16'h0008; end
         S_WR_SNAP: begin bus_cs = 1'b1; bus_wr_n = 1'b0; bus_addr = 3'd4; end
         S_RD_L:    begin bus_cs = 1'b1; bus_addr = 3'd4; end
         S_RD_H:    begin bus_cs = 1'b1; bus_addr = 3'd5; end
         S_CLR_ST:  begin bus_cs = 1'b1; bus_wr_n = 1'b0; bus_addr = 3'd0; end
         default:   ;
      endcase
   end

   // Control state, bus outputs, snapshot result and timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_address    <= 3'd0;
         avm_writedata  <= 16'h0000;
         snap_valid     <= 1'b0;
         snap_value     <= 32'h0000_0000;
         tick_pulse     <= 1'b0;
         tick_count     <= '0;
      end else begin
         state          <= state_nxt;
         avm_chipselect <= bus_cs;
         avm_write_n    <= bus_wr_n;
         avm_address    <= bus_addr;
         avm_writedata  <= bus_wdata;
         snap_valid     <= (state == S_CAP_H);
         if (state == S_CAP_H)
            snap_value <= {avm_readdata, snap_lo_p0};
         tick_pulse     <= (state_nxt == S_GUARD);
         if (accept && (cmd_op == OP_CONFIG))
            tick_count <= '0;
         else if (state_nxt == S_GUARD)
            tick_count <= tick_next(tick_count);
      end
   end

   // Command operands held for the later writes, and the low snapshot half (data only, no reset).
   always_ff @(posedge clk) begin
      if (accept) begin
         period_hi_p0 <= cmd_period[31:16];
         cont_p0      <= cmd_continuous;
         ito_p0       <= cmd_irq_en;
      end
      if (state == S_RD_H)
         snap_lo_p0 <= avm_readdata;
   end

endmodule
